// File: rtl/inst_rom_arbiter_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
// Widths and encodings match the legacy defines used by the fetch path.
package inst_rom_arbiter_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t      ZERO_WORD    = '0;
  localparam inst_addr_t ZERO_ADDR    = '0;
  localparam logic       CHIP_ENABLE  = 1'b1;
  localparam logic       CHIP_DISABLE = 1'b0;
  localparam logic       RST_ENABLE   = 1'b1;
  localparam int         ARB_WAIT_MAX = 4;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_DBG  = 2'd2
  } rom_owner_e;
endpackage

// File: rtl/inst_rom_arbiter_if.sv
// Bundle of the IF, DBG and ROM-side signals around the arbiter.
// master = arbiter side, slave = requesters plus ROM.
interface inst_rom_arbiter_if import inst_rom_arbiter_pkg::*; ();
  logic       if_req;
  inst_addr_t if_addr;
  logic       if_gnt;
  logic       if_ack;
  inst_t      if_inst;
  logic       dbg_req;
  inst_addr_t dbg_addr;
  logic       dbg_gnt;
  logic       dbg_ack;
  inst_t      dbg_inst;
  logic       rom_ce;
  inst_addr_t rom_addr;
  inst_t      rom_inst;
  logic       stallreq_if;

  modport master (
    input  if_req, if_addr, dbg_req, dbg_addr, rom_inst,
    output if_gnt, if_ack, if_inst, dbg_gnt, dbg_ack, dbg_inst,
    output rom_ce, rom_addr, stallreq_if
  );

  modport slave (
    output if_req, if_addr, dbg_req, dbg_addr, rom_inst,
    input  if_gnt, if_ack, if_inst, dbg_gnt, dbg_ack, dbg_inst,
    input  rom_ce, rom_addr, stallreq_if
  );
endinterface

// File: rtl/inst_rom_arbiter_wait_counter.sv
// Counts consecutive cycles a pending DBG request has been denied;
// starve flags that DBG must win the next contended cycle.
module inst_rom_arbiter_wait_counter import inst_rom_arbiter_pkg::*; #(
  parameter int MAX_WAIT = ARB_WAIT_MAX,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic starve
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || dbg_gnt || !dbg_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + CNT_ONE;
    end
  end

  assign starve = (wait_cnt == MAX_CNT);
endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares the combinational instruction ROM between fetch (IF) and a debug
// read port (DBG); IF has priority, DBG is guaranteed a slot after MAX_WAIT denials.
module inst_rom_arbiter import inst_rom_arbiter_pkg::*; #(
  parameter int MAX_WAIT = ARB_WAIT_MAX,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  inst_rom_arbiter_if.master bus
);
  logic       starve;
  logic       if_gnt_p0, dbg_gnt_p0;
  rom_owner_e owner_p0;
  logic       rom_ce_p0;
  inst_addr_t rom_addr_p0;
  logic       if_ack_p1, dbg_ack_p1;
  inst_t      if_inst_p1, dbg_inst_p1;

  inst_rom_arbiter_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .dbg_req (bus.dbg_req),
    .dbg_gnt (dbg_gnt_p0),
    .starve  (starve)
  );

  // p0: grant decision and ROM drive, all combinational
  always_comb begin
    dbg_gnt_p0 = bus.dbg_req & (~bus.if_req | starve);
    if_gnt_p0  = bus.if_req & ~dbg_gnt_p0;
    owner_p0   = OWNER_NONE;
    if (if_gnt_p0) begin
      owner_p0 = OWNER_IF;
    end else if (dbg_gnt_p0) begin
      owner_p0 = OWNER_DBG;
    end
  end

  always_comb begin
    rom_ce_p0   = CHIP_DISABLE;
    rom_addr_p0 = ZERO_ADDR;
    unique case (owner_p0)
      OWNER_IF: begin
        rom_ce_p0   = CHIP_ENABLE;
        rom_addr_p0 = bus.if_addr;
      end
      OWNER_DBG: begin
        rom_ce_p0   = CHIP_ENABLE;
        rom_addr_p0 = bus.dbg_addr;
      end
      default: ;
    endcase
  end

  // p1: responses registered; reset suppresses the ack of the grant in flight
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      if_ack_p1   <= 1'b0;
      dbg_ack_p1  <= 1'b0;
      if_inst_p1  <= ZERO_WORD;
      dbg_inst_p1 <= ZERO_WORD;
    end else begin
      if_ack_p1  <= if_gnt_p0;
      dbg_ack_p1 <= dbg_gnt_p0;
      if (if_gnt_p0) begin
        if_inst_p1 <= bus.rom_inst;
      end
      if (dbg_gnt_p0) begin
        dbg_inst_p1 <= bus.rom_inst;
      end
    end
  end

  assign bus.if_gnt      = if_gnt_p0;
  assign bus.dbg_gnt     = dbg_gnt_p0;
  assign bus.stallreq_if = bus.if_req & ~if_gnt_p0;
  assign bus.rom_ce      = rom_ce_p0;
  assign bus.rom_addr    = rom_addr_p0;
  assign bus.if_ack      = if_ack_p1;
  assign bus.dbg_ack     = dbg_ack_p1;
  assign bus.if_inst     = if_inst_p1;
  assign bus.dbg_inst    = dbg_inst_p1;
endmodule
